// File: rtl/flag_checker_stream.sv
// Streaming flag checker: each accepted word passes through a keyed, chained rotate/add
// transform and is compared against a programmable target table, yielding pass and first-mismatch index.
module flag_checker_stream #(
  parameter int                DATA_W   = 8,
  parameter int                LEN      = 32,
  parameter logic [DATA_W-1:0] KEY_INIT = DATA_W'(8'h5A),
  parameter int                ROT      = 3,
  parameter bit                CHAIN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       inp,
  output logic                    res_valid,
  output logic [DATA_W-1:0]       res,
  input  logic                    tgt_we,
  input  logic [$clog2(LEN)-1:0]  tgt_addr,
  input  logic [DATA_W-1:0]       tgt_data,
  output logic                    done,
  output logic                    pass,
  output logic [$clog2(LEN)-1:0]  mismatch_idx
);

  localparam int              AW       = $clog2(LEN);
  localparam logic [AW-1:0]   LAST_IDX = AW'(LEN - 1);
  localparam logic [AW:0]     LEN_W    = (AW + 1)'(LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic                ok_q, ok_d;
  logic [AW-1:0]       mis_q, mis_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                res_valid_q, res_valid_d;

  logic [DATA_W-1:0]   tgt_mem [LEN];
  logic [DATA_W-1:0]   res_next;
  logic                accept;
  logic                tgt_wr_ok;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
    logic [2*DATA_W-1:0] d;
    d = {x, x} << ROT;
    return d[2*DATA_W-1:DATA_W];
  endfunction

  // A start in the same cycle wins over the presented word.
  assign accept    = in_valid && (state_q == S_RUN) && !start;
  assign res_next  = rotl(inp ^ key_q) + DATA_W'(idx_q);
  assign tgt_wr_ok = tgt_we && (state_q == S_IDLE || state_q == S_DONE)
                     && ({1'b0, tgt_addr} < LEN_W);

  // Target table is deliberately left out of reset so it survives rst.
  always_ff @(posedge clk) begin
    if (tgt_wr_ok) begin
      tgt_mem[tgt_addr] <= tgt_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    ok_d        = ok_q;
    mis_d       = mis_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          res_d       = res_next;
          res_valid_d = 1'b1;
          idx_d       = idx_q + 1'b1;
          if (CHAIN) begin
            key_d = res_next;
          end
          if (res_next != tgt_mem[idx_q]) begin
            ok_d = 1'b0;
            if (ok_q) begin
              mis_d = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (start) begin
      state_d = S_RUN;
      idx_d   = '0;
      key_d   = KEY_INIT;
      ok_d    = 1'b1;
      mis_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      key_q       <= KEY_INIT;
      ok_q        <= 1'b1;
      mis_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      ok_q        <= ok_d;
      mis_q       <= mis_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign res_valid    = res_valid_q;
  assign res          = res_q;
  assign done         = (state_q == S_DONE);
  assign pass         = done && ok_q;
  assign mismatch_idx = mis_q;

endmodule

// File: tb/tb_flag_checker_stream.sv
// Bench for flag_checker_stream: table vectors, a golden-model stream with random gaps,
// corrupted targets, aborts, async reset and a 16-bit instance.
module tb_flag_checker_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 8-bit instances
  logic       start, in_valid, tgt_we;
  logic [7:0] inp, tgt_data;
  logic [4:0] tgt_addr;
  logic       in_ready0, res_valid0, done0, pass0;
  logic [7:0] res0;
  logic [4:0] mis0;
  logic       in_ready1, res_valid1, done1, pass1;
  logic [7:0] res1;
  logic [4:0] mis1;

  logic        start2, in_valid2, tgt_we2;
  logic [15:0] inp2, tgt_data2;
  logic [1:0]  tgt_addr2;
  logic        in_ready2, res_valid2, done2, pass2;
  logic [15:0] res2;
  logic [1:0]  mis2;

  flag_checker_stream #(.DATA_W(8), .LEN(32), .ROT(3), .CHAIN(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .inp(inp), .res_valid(res_valid0), .res(res0), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
    .tgt_data(tgt_data), .done(done0), .pass(pass0), .mismatch_idx(mis0));

  flag_checker_stream #(.DATA_W(8), .LEN(32), .ROT(3), .CHAIN(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .inp(inp), .res_valid(res_valid1), .res(res1), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
    .tgt_data(tgt_data), .done(done1), .pass(pass1), .mismatch_idx(mis1));

  flag_checker_stream #(.DATA_W(16), .LEN(4), .ROT(5), .CHAIN(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .inp(inp2), .res_valid(res_valid2), .res(res2), .tgt_we(tgt_we2), .tgt_addr(tgt_addr2),
    .tgt_data(tgt_data2), .done(done2), .pass(pass2), .mismatch_idx(mis2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] w;
    logic [7:0] exp_chain;
    logic [7:0] exp_flat;
  } vec_t;

  vec_t       vecs [2];
  logic [7:0] msg  [32];
  logic [7:0] gold [32];
  logic [15:0] w2 [4];
  logic [15:0] g2 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: rotate-left then add index, all modulo 2^wb.
  function automatic logic [31:0] model_xf(input int wb, input int rot, input logic [31:0] w,
                                           input logic [31:0] key, input int idx);
    logic [31:0] mask, x, t;
    mask = (32'd1 << wb) - 32'd1;
    x = (w ^ key) & mask;
    t = ((x << rot) | (x >> (wb - rot))) & mask;
    return (t + 32'(idx)) & mask;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    inp = w;
    while (!in_ready0 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready0), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int n, input int max_gap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        tick();
        chk("gap_res_valid", 32'(res_valid0), 32'd0);
      end
      send_word(msg[i]);
      chk("res_valid", 32'(res_valid0), 32'd1);
      chk($sformatf("res[%0d]", i), 32'(res0), 32'(gold[i]));
    end
  endtask

  task automatic check_verdict(input logic exp_pass, input logic [4:0] exp_idx);
    chk("flush_in_ready", 32'(in_ready0), 32'd0);
    chk("flush_done", 32'(done0), 32'd0);
    tick();
    chk("done", 32'(done0), 32'd1);
    chk("pass", 32'(pass0), 32'(exp_pass));
    chk("mismatch_idx", 32'(mis0), 32'(exp_idx));
    chk("done_in_ready", 32'(in_ready0), 32'd0);
    chk("done_res_valid", 32'(res_valid0), 32'd0);
  endtask

  task automatic write_tgt(input logic [4:0] a, input logic [7:0] d);
    tgt_we = 1'b1;
    tgt_addr = a;
    tgt_data = d;
    tick();
    tgt_we = 1'b0;
  endtask

  initial begin
    string s;
    logic [31:0] key;
    vecs[0] = '{w: 8'h66, exp_chain: 8'hE1, exp_flat: 8'hE1};
    vecs[1] = '{w: 8'h6C, exp_chain: 8'h6D, exp_flat: 8'hB2};

    s = "flag{stream_checker_is_correct!}";
    key = 32'h5A;
    for (int i = 0; i < 32; i++) begin
      msg[i]  = s[i];
      gold[i] = model_xf(8, 3, 32'(msg[i]), key, i)[7:0];
      key     = 32'(gold[i]);
    end

    start = 0; in_valid = 0; tgt_we = 0; inp = 0; tgt_data = 0; tgt_addr = 0;
    start2 = 0; in_valid2 = 0; tgt_we2 = 0; inp2 = 0; tgt_data2 = 0; tgt_addr2 = 0;

    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_res_valid", 32'(res_valid0), 32'd0);
    chk("rst_res", 32'(res0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_mismatch_idx", 32'(mis0), 32'd0);
    chk("rst_res_w16", 32'(res2), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready0), 32'd0);

    for (int i = 0; i < 32; i++) write_tgt(5'(i), gold[i]);

    // Table vectors: first two words, chained and unchained key
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      send_word(vecs[i].w);
      chk($sformatf("vec%0d_res_valid", i), 32'(res_valid0), 32'd1);
      chk($sformatf("vec%0d_res_chain", i), 32'(res0), 32'(vecs[i].exp_chain));
      chk($sformatf("vec%0d_res_flat", i), 32'(res1), 32'(vecs[i].exp_flat));
      tick();
      chk($sformatf("vec%0d_pulse_end", i), 32'(res_valid0), 32'd0);
      chk($sformatf("vec%0d_res_hold", i), 32'(res0), 32'(vecs[i].exp_chain));
    end

    // Full golden stream with random gaps
    pulse_start();
    run_stream(32, 3);
    check_verdict(1'b1, 5'd0);

    // Corrupted targets: first mismatch is reported
    write_tgt(5'd5, gold[5] ^ 8'h01);
    write_tgt(5'd20, gold[20] ^ 8'h80);
    pulse_start();
    run_stream(32, 1);
    check_verdict(1'b0, 5'd5);

    // Restore, then try to overwrite during RUN
    write_tgt(5'd5, gold[5]);
    write_tgt(5'd20, gold[20]);
    pulse_start();
    write_tgt(5'd7, ~gold[7]);
    run_stream(32, 0);
    check_verdict(1'b1, 5'd0);

    // Abort after 10 words; the word presented with start is dropped
    pulse_start();
    run_stream(10, 1);
    start = 1'b1;
    in_valid = 1'b1;
    inp = msg[0];
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_word_dropped", 32'(res_valid0), 32'd0);
    chk("restart_in_ready", 32'(in_ready0), 32'd1);
    run_stream(32, 1);
    check_verdict(1'b1, 5'd0);

    // Asynchronous reset mid-stream
    pulse_start();
    run_stream(5, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready0), 32'd0);
    chk("arst_res_valid", 32'(res_valid0), 32'd0);
    chk("arst_res", 32'(res0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("arst_idle", 32'(in_ready0), 32'd0);
    pulse_start();
    run_stream(32, 0);
    check_verdict(1'b1, 5'd0);

    // 16-bit instance; last word lands on t=0xFFFF at idx=3
    key = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      w2[i] = 16'($urandom);
      g2[i] = model_xf(16, 5, 32'(w2[i]), key, i)[15:0];
      key   = 32'(g2[i]);
    end
    w2[3] = key[15:0] ^ 16'hFFFF;
    g2[3] = model_xf(16, 5, 32'(w2[3]), key, 3)[15:0];
    for (int i = 0; i < 4; i++) begin
      tgt_we2 = 1'b1;
      tgt_addr2 = 2'(i);
      tgt_data2 = g2[i];
      tick();
    end
    tgt_we2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w16_in_ready", 32'(in_ready2), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      inp2 = w2[i];
      tick();
      chk($sformatf("w16_res_valid[%0d]", i), 32'(res_valid2), 32'd1);
      chk($sformatf("w16_res[%0d]", i), 32'(res2), (i == 3) ? 32'h0002 : 32'(g2[i]));
    end
    in_valid2 = 1'b0;
    chk("w16_flush_done", 32'(done2), 32'd0);
    tick();
    chk("w16_done", 32'(done2), 32'd1);
    chk("w16_pass", 32'(pass2), 32'd1);
    chk("w16_mismatch_idx", 32'(mis2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
